tdm_demux_2ch: RTL

TDM_DEMUX_2CH -- requirements
Module: tdm_demux_2ch

---
 rtl/tdm_demux_2ch.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/tdm_demux_2ch.sv
// Two-slot TDM demultiplexer: recovers d0/d1 from a serial stream using a slot marker,
// with lock/loss hysteresis and a saturating sync-error counter.
module tdm_demux_2ch #(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       tdm_in,
  input  logic       sync_in,
  output logic       d0_out,
  output logic       d1_out,
  output logic       pair_valid,
  output logic       locked,
  output logic       sync_err,
  output logic [7:0] err_cnt
);

  localparam logic [3:0] LockCnt = 4'(LOCK_COUNT);
  localparam logic [3:0] LossCnt = 4'(LOSS_COUNT);

  typedef enum logic [1:0] {StHunt, StSlot1, StSlot0} state_e;

  state_e     state_q, state_d;
  logic       hold0_q, hold0_d;
  logic       d0_q, d0_d;
  logic       d1_q, d1_d;
  logic       pair_valid_q, pair_valid_d;
  logic       locked_q, locked_d;
  logic       sync_err_q, sync_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [3:0] good_run_q, good_run_d;
  logic [3:0] err_run_q, err_run_d;
  logic       pair_done;
  logic       slot_err;

  // Slot-order FSM; pair_done and slot_err are mutually exclusive by construction.
  always_comb begin
    state_d   = state_q;
    hold0_d   = hold0_q;
    pair_done = 1'b0;
    slot_err  = 1'b0;
    if (en) begin
      case (state_q)
        StHunt: begin
          if (sync_in) begin
            hold0_d = tdm_in;
            state_d = StSlot1;
          end
        end
        StSlot1: begin
          if (sync_in) begin
            slot_err = 1'b1;
            hold0_d  = tdm_in;
          end else begin
            pair_done = 1'b1;
            state_d   = StSlot0;
          end
        end
        StSlot0: begin
          if (sync_in) begin
            hold0_d = tdm_in;
            state_d = StSlot1;
          end else begin
            slot_err = 1'b1;
            state_d  = StHunt;
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_comb begin
    d0_d       = d0_q;
    d1_d       = d1_q;
    good_run_d = good_run_q;
    err_run_d  = err_run_q;
    locked_d   = locked_q;
    err_cnt_d  = err_cnt_q;
    if (pair_done) begin
      d0_d      = hold0_q;
      d1_d      = tdm_in;
      err_run_d = 4'd0;
      if (good_run_q != LockCnt) begin
        good_run_d = good_run_q + 4'd1;
      end
      if (good_run_d == LockCnt) begin
        locked_d = 1'b1;
      end
    end
    if (slot_err) begin
      good_run_d = 4'd0;
      if (err_run_q != 4'hf) begin
        err_run_d = err_run_q + 4'd1;
      end
      if (err_run_d == LossCnt) begin
        locked_d = 1'b0;
      end
      if (err_cnt_q != 8'hff) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
    pair_valid_d = pair_done & locked_d;
    sync_err_d   = slot_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StHunt;
      hold0_q      <= 1'b0;
      d0_q         <= 1'b0;
      d1_q         <= 1'b0;
      pair_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      sync_err_q   <= 1'b0;
      err_cnt_q    <= 8'd0;
      good_run_q   <= 4'd0;
      err_run_q    <= 4'd0;
    end else begin
      state_q      <= state_d;
      hold0_q      <= hold0_d;
      d0_q         <= d0_d;
      d1_q         <= d1_d;
      pair_valid_q <= pair_valid_d;
      locked_q     <= locked_d;
      sync_err_q   <= sync_err_d;
      err_cnt_q    <= err_cnt_d;
      good_run_q   <= good_run_d;
      err_run_q    <= err_run_d;
    end
  end

  assign d0_out     = d0_q;
  assign d1_out     = d1_q;
  assign pair_valid = pair_valid_q;
  assign locked     = locked_q;
  assign sync_err   = sync_err_q;
  assign err_cnt    = err_cnt_q;

endmodule
